// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared raster constants for the VGA pipeline. Holds the default 640x480@60
// timing, the derived line/frame totals, and the sync polarity constants.
// The colour/pattern stage imports this package so that both stages agree on
// the raster geometry.
// Contents:
//   *_DEF timing localparams  - default porch/sync/active sizes
//   H_TOTAL_DEF / V_TOTAL_DEF - clocks per line, lines per frame
//   SYNC_ACTIVE_LOW/HIGH      - sync polarity constants
//   vga_sync_t                - bundle of active/hsync/vsync, one delay stage
//   bitsFor()                 - bits needed to hold a given maximum value
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;
    localparam bit HSYNC_POL_DEF    = SYNC_ACTIVE_LOW;
    localparam bit VSYNC_POL_DEF    = SYNC_ACTIVE_LOW;

    localparam int CW_DEF         = 10;
    localparam int SYNC_DELAY_MAX = 7;

    // One stage of the sync/active delay line.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } vga_sync_t;

    // Smallest bit count whose range covers maxVal (at least 1).
    function automatic int bitsFor(input int maxVal);
        int n;
        n = 31;
        for (int i = 30; i >= 1; i--) begin
            if ((1 << i) > maxVal) begin
                n = i;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// ---------------------------------------------------------------------------
// vga_timing_if
// Bundle between the raster timing generator and its consumer.
// Signals:
//   pix_en      - pixel-step enable, driven by the consumer side
//   x, y        - coordinates of the current output pixel/line (CW bits)
//   active      - inside the visible area
//   hsync/vsync - sync outputs at the configured polarity
//   line_start  - one-clock pulse when x/y move to h=0
//   frame_start - one-clock pulse when x/y move to (0,0)
// Modports:
//   master - the timing generator
//   slave  - the pattern/framebuffer stage (or a testbench)
// ---------------------------------------------------------------------------
interface vga_timing_if
    import vga_pkg::*;
#(
    parameter int CW = CW_DEF
);

    logic          pix_en;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          active;
    logic          hsync;
    logic          vsync;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  pix_en,
        output x, y, active, hsync, vsync, line_start, frame_start
    );

    modport slave (
        output pix_en,
        input  x, y, active, hsync, vsync, line_start, frame_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One raster axis (horizontal or vertical). Counts 0..TOTAL-1 and decodes
// where the count lies within the active/front/sync/back regions.
// Ports:
//   clock, reset - pixel clock, asynchronous active-high reset
//   i_step       - advance the counter on this clock
//   i_wrap       - when stepping, return to 0 instead of incrementing
//   o_count      - current count
//   o_tc         - count is at TOTAL-1 (terminal count)
//   o_inSync     - count lies in the sync pulse window
//   o_inActive   - count lies in the visible region
// ---------------------------------------------------------------------------
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FRONT  = H_FRONT_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BACK   = H_BACK_DEF,
    parameter int CW     = CW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_step,
    input  logic          i_wrap,
    output logic [CW-1:0] o_count,
    output logic          o_tc,
    output logic          o_inSync,
    output logic          o_inActive
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

    localparam logic [CW-1:0] TC_VAL     = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_FIRST = CW'(ACTIVE + FRONT);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [CW-1:0] ACT_LIMIT  = CW'(ACTIVE);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_step) begin
            if (i_wrap) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count    = r_count;
    assign o_tc       = (r_count == TC_VAL);
    assign o_inSync   = (r_count >= SYNC_FIRST) && (r_count <= SYNC_LAST);
    assign o_inActive = (r_count < ACT_LIMIT);

endmodule

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Raster timing generator for the VGA colour stage. Two axis counters walk
// the raster; every enabled step the current position is registered onto
// x/y together with the raw active/hsync/vsync decode. The decode then runs
// through SYNC_DELAY enable-qualified stages so that sync stays aligned with
// a colour pipeline of that depth. line_start/frame_start are evaluated on
// every clock, so they stay one clock wide regardless of pix_en.
// Ports:
//   clock - pixel clock from the PLL
//   reset - asynchronous, active-high
//   bus   - vga_timing_if master: pix_en in; x, y, active, hsync, vsync,
//           line_start, frame_start out
// ---------------------------------------------------------------------------
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter bit HSYNC_POL  = HSYNC_POL_DEF,
    parameter bit VSYNC_POL  = VSYNC_POL_DEF,
    parameter int CW         = CW_DEF,
    parameter int SYNC_DELAY = 0
) (
    input logic         clock,
    input logic         reset,
    vga_timing_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam vga_sync_t SYNC_IDLE = '{active: 1'b0, hsync: ~HSYNC_POL, vsync: ~VSYNC_POL};

    // Configuration errors are caught at elaboration rather than producing a
    // silently truncated raster.
    if (bitsFor(H_TOTAL - 1) > CW || bitsFor(V_TOTAL - 1) > CW) begin : g_cwTooNarrow
        $error("vga_timing: CW=%0d cannot hold H_TOTAL-1=%0d / V_TOTAL-1=%0d",
               CW, H_TOTAL - 1, V_TOTAL - 1);
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > SYNC_DELAY_MAX) begin : g_badSyncDelay
        $error("vga_timing: SYNC_DELAY=%0d outside 0..%0d", SYNC_DELAY, SYNC_DELAY_MAX);
    end
    if (H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_badGeometry
        $error("vga_timing: active and sync widths must be at least 1");
    end

    logic [CW-1:0] w_hCount;
    logic          w_hTc;
    logic          w_hInSync;
    logic          w_hInActive;
    logic [CW-1:0] w_vCount;
    logic          w_vTc;
    logic          w_vInSync;
    logic          w_vInActive;
    logic          w_vStep;
    logic          w_hZero;
    logic          w_vZero;

    // The vertical axis only moves on the last pixel of a line.
    assign w_vStep = bus.pix_en & w_hTc;
    assign w_hZero = (w_hCount == '0);
    assign w_vZero = (w_vCount == '0);

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .CW     (CW)
    ) u_hCounter (
        .clock      (clock),
        .reset      (reset),
        .i_step     (bus.pix_en),
        .i_wrap     (w_hTc),
        .o_count    (w_hCount),
        .o_tc       (w_hTc),
        .o_inSync   (w_hInSync),
        .o_inActive (w_hInActive)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .CW     (CW)
    ) u_vCounter (
        .clock      (clock),
        .reset      (reset),
        .i_step     (w_vStep),
        .i_wrap     (w_vTc),
        .o_count    (w_vCount),
        .o_tc       (w_vTc),
        .o_inSync   (w_vInSync),
        .o_inActive (w_vInActive)
    );

    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    vga_sync_t     r_raw;
    logic          r_lineStart;
    logic          r_frameStart;

    // Start pulses sit outside the pix_en qualification: with pix_en held
    // high h leaves 0 after one step, and with pix_en low the pulse drops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x          <= '0;
            r_y          <= '0;
            r_raw        <= SYNC_IDLE;
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
        end else begin
            r_lineStart  <= bus.pix_en & w_hZero;
            r_frameStart <= bus.pix_en & w_hZero & w_vZero;
            if (bus.pix_en) begin
                r_x          <= w_hCount;
                r_y          <= w_vCount;
                r_raw.active <= w_hInActive & w_vInActive;
                r_raw.hsync  <= w_hInSync ? HSYNC_POL : ~HSYNC_POL;
                r_raw.vsync  <= w_vInSync ? VSYNC_POL : ~VSYNC_POL;
            end
        end
    end

    vga_sync_t w_syncOut;

    if (SYNC_DELAY == 0) begin : g_noDelay
        assign w_syncOut = r_raw;
    end else begin : g_delay
        vga_sync_t r_stage [SYNC_DELAY];

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < SYNC_DELAY; i++) begin
                    r_stage[i] <= SYNC_IDLE;
                end
            end else if (bus.pix_en) begin
                r_stage[0] <= r_raw;
                for (int i = 1; i < SYNC_DELAY; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign w_syncOut = r_stage[SYNC_DELAY-1];
    end

    assign bus.x           = r_x;
    assign bus.y           = r_y;
    assign bus.active      = w_syncOut.active;
    assign bus.hsync       = w_syncOut.hsync;
    assign bus.vsync       = w_syncOut.vsync;
    assign bus.line_start  = r_lineStart;
    assign bus.frame_start = r_frameStart;

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
// Drives two generators from one pix_en/reset: dutA with the default
// 640x480@60 timing and no sync delay, dutB with a tiny 16x9 raster,
// active-high vsync and SYNC_DELAY=2. Each clock the stimulus pushes the
// expected outputs of both into queues; a monitor pops and compares them.
// Directed measurements (sync widths, periods, delay offsets) follow each
// stimulus phase.
// ---------------------------------------------------------------------------
module tb_vga_timing;
    import vga_pkg::*;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit hpol, vpol;
        int d;
    } tim_t;

    typedef struct {
        int x, y;
        bit active, hsync, vsync, ls, fs;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic pixEn;

    int checkCount = 0;
    int errorCount = 0;
    int stepCount  = 0;
    bit capOn      = 1'b0;

    tim_t timA, timB;
    exp_t expA[$];
    exp_t expB[$];

    int capXA[$];
    bit capHsA[$], capActA[$], capLsA[$];
    int capXB[$], capYB[$];
    bit capHsB[$], capActB[$], capVsB[$], capFsB[$];

    always #5 clock = ~clock;

    vga_timing_if #(.CW(10)) busA ();
    vga_timing_if #(.CW(4))  busB ();

    assign busA.pix_en = pixEn;
    assign busB.pix_en = pixEn;

    vga_timing dutA (
        .clock (clock),
        .reset (reset),
        .bus   (busA)
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b1), .CW(4), .SYNC_DELAY(2)
    ) dutB (
        .clock (clock),
        .reset (reset),
        .bus   (busB)
    );

    task automatic compareField(input string name, input int act, input int expv);
        checkCount++;
        if (act != expv) begin
            errorCount++;
            if (errorCount <= 30) begin
                $display("[TB] FAIL %s got %0d expected %0d", name, act, expv);
            end
        end
    endtask

    // Expected outputs after k enabled steps since reset, written from the
    // raster formulas: step j shows position (j-1) mod frame.
    function automatic exp_t predict(input tim_t t, input int k, input bit en);
        exp_t e;
        int ht, vt, p, j, h, v;
        ht = t.ha + t.hf + t.hs + t.hb;
        vt = t.va + t.vf + t.vs + t.vb;
        e.x = 0; e.y = 0; e.active = 1'b0;
        e.hsync = !t.hpol; e.vsync = !t.vpol;
        e.ls = 1'b0; e.fs = 1'b0;
        if (k == 0) return e;
        p   = (k - 1) % (ht * vt);
        e.x = p % ht;
        e.y = p / ht;
        if (en) begin
            e.ls = (e.x == 0);
            e.fs = (p == 0);
        end
        j = k - t.d;
        if (j >= 1) begin
            p = (j - 1) % (ht * vt);
            h = p % ht;
            v = p / ht;
            e.active = (h < t.ha) && (v < t.va);
            e.hsync  = (h >= t.ha + t.hf && h < t.ha + t.hf + t.hs) ? t.hpol : !t.hpol;
            e.vsync  = (v >= t.va + t.vf && v < t.va + t.vf + t.vs) ? t.vpol : !t.vpol;
        end
        return e;
    endfunction

    task automatic applyStimulus(input bit en, input bit rst);
        @(negedge clock);
        if (capOn) begin
            capXA.push_back(int'(busA.x));   capHsA.push_back(busA.hsync);
            capActA.push_back(busA.active);  capLsA.push_back(busA.line_start);
            capXB.push_back(int'(busB.x));   capYB.push_back(int'(busB.y));
            capHsB.push_back(busB.hsync);    capActB.push_back(busB.active);
            capVsB.push_back(busB.vsync);    capFsB.push_back(busB.frame_start);
        end
        pixEn = en;
        reset = rst;
        if (rst) stepCount = 0;
        else if (en) stepCount++;
        expA.push_back(predict(timA, stepCount, en && !rst));
        expB.push_back(predict(timB, stepCount, en && !rst));
    endtask

    task automatic checkOutput(input string tag, input exp_t e, input int x, input int y,
                               input bit act, input bit hs, input bit vs, input bit ls, input bit fs);
        compareField({tag, ".x"}, x, e.x);
        compareField({tag, ".y"}, y, e.y);
        compareField({tag, ".active"}, int'(act), int'(e.active));
        compareField({tag, ".hsync"}, int'(hs), int'(e.hsync));
        compareField({tag, ".vsync"}, int'(vs), int'(e.vsync));
        compareField({tag, ".line_start"}, int'(ls), int'(e.ls));
        compareField({tag, ".frame_start"}, int'(fs), int'(e.fs));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (expA.size() > 0) begin
                e = expA.pop_front();
                checkOutput("A", e, int'(busA.x), int'(busA.y), busA.active, busA.hsync,
                            busA.vsync, busA.line_start, busA.frame_start);
            end
            if (expB.size() > 0) begin
                e = expB.pop_front();
                checkOutput("B", e, int'(busB.x), int'(busB.y), busB.active, busB.hsync,
                            busB.vsync, busB.line_start, busB.frame_start);
            end
        end
    end

    task automatic clearCapture();
        capXA.delete(); capHsA.delete(); capActA.delete(); capLsA.delete();
        capXB.delete(); capYB.delete(); capHsB.delete(); capActB.delete();
        capVsB.delete(); capFsB.delete();
    endtask

    // Call right after an enabled edge that follows reset release.
    task automatic checkFirstEdge(input string tag);
        @(posedge clock);
        #3;
        compareField({tag, " A.x"}, int'(busA.x), 0);
        compareField({tag, " A.y"}, int'(busA.y), 0);
        compareField({tag, " A.active"}, int'(busA.active), 1);
        compareField({tag, " A.hsync"}, int'(busA.hsync), 1);
        compareField({tag, " A.vsync"}, int'(busA.vsync), 1);
        compareField({tag, " A.frame_start"}, int'(busA.frame_start), 1);
        compareField({tag, " B.frame_start"}, int'(busB.frame_start), 1);
        compareField({tag, " B.vsync"}, int'(busB.vsync), 0);
    endtask

    task automatic analyzeLine(input string tag, input int mult);
        int f1, f2, lowW, actCnt, lsRun, lsMax, i;
        f1 = -1; f2 = -1; lowW = 0; actCnt = 0; lsRun = 0; lsMax = 0;
        for (int n = 1; n < capHsA.size(); n++) begin
            if (capHsA[n-1] && !capHsA[n]) begin
                if (f1 < 0) f1 = n;
                else if (f2 < 0) f2 = n;
            end
        end
        compareField({tag, " two hsync falls seen"}, int'(f1 >= 0 && f2 >= 0), 1);
        if (f1 < 0 || f2 < 0) return;
        i = f1;
        while (i < f2 && !capHsA[i]) begin
            lowW++;
            i++;
        end
        for (int n = f1; n < f2; n++) actCnt += int'(capActA[n]);
        foreach (capLsA[n]) begin
            lsRun = capLsA[n] ? lsRun + 1 : 0;
            if (lsRun > lsMax) lsMax = lsRun;
        end
        compareField({tag, " hsync period"}, f2 - f1, 800 * mult);
        compareField({tag, " hsync low width"}, lowW, 96 * mult);
        compareField({tag, " x at hsync fall"}, capXA[f1], 656);
        compareField({tag, " active per line"}, actCnt, 640 * mult);
        compareField({tag, " line_start width"}, lsMax, 1);
    endtask

    task automatic analyzeDelayB();
        int xi, ai, fs, j, actSum, vsSum, fsSum;
        xi = -1; ai = -1; fs = -1;
        for (int n = 1; n < capXB.size() - 4; n++) begin
            if (xi < 0 && capXB[n] == 10 && capXB[n-1] != 10) xi = n;
            if (ai < 0 && capXB[n] == 8 && capXB[n-1] != 8 && capYB[n] < 4) ai = n;
            if (fs < 0 && capFsB[n]) fs = n;
        end
        compareField("B delay anchors found", int'(xi > 0 && ai > 0 && fs > 0), 1);
        if (xi <= 0 || ai <= 0 || fs <= 0) return;
        j = xi;
        while (j < capHsB.size() - 1 && !(capHsB[j-1] && !capHsB[j])) j++;
        compareField("B hsync fall after x=10", j - xi, 2);
        j = ai;
        while (j < capActB.size() - 1 && !(capActB[j-1] && !capActB[j])) j++;
        compareField("B active fall after x=8", j - ai, 2);
        compareField("B frame window fits", int'(fs + 144 <= capActB.size()), 1);
        if (fs + 144 > capActB.size()) return;
        actSum = 0; vsSum = 0; fsSum = 0;
        for (int n = fs; n < fs + 144; n++) begin
            actSum += int'(capActB[n]);
            vsSum  += int'(capVsB[n]);
            fsSum  += int'(capFsB[n]);
        end
        compareField("B active clocks per frame", actSum, 32);
        compareField("B vsync clocks per frame", vsSum, 32);
        compareField("B frame_start per frame", fsSum, 1);
    endtask

    initial begin : stimulus
        timA = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0};
        timB = '{8, 2, 3, 3, 4, 1, 2, 2, 1'b0, 1'b1, 2};
        reset = 1'b1;
        pixEn = 1'b0;
        $display("[TB] reset and first enabled edge");
        repeat (3) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkFirstEdge("first edge");
        applyStimulus(1'b1, 1'b0);
        @(posedge clock);
        #3;
        compareField("frame_start one clock", int'(busA.frame_start), 0);

        $display("[TB] continuous pix_en");
        clearCapture();
        capOn = 1'b1;
        repeat (1700) applyStimulus(1'b1, 1'b0);
        capOn = 1'b0;
        analyzeLine("cont", 1);
        analyzeDelayB();

        $display("[TB] pix_en toggling");
        clearCapture();
        capOn = 1'b1;
        for (int n = 0; n < 3400; n++) applyStimulus(n % 2 == 0, 1'b0);
        capOn = 1'b0;
        analyzeLine("toggle", 2);

        $display("[TB] mid-frame reset");
        repeat (300) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        #1;
        compareField("async reset A.x", int'(busA.x), 0);
        compareField("async reset A.y", int'(busA.y), 0);
        compareField("async reset A.hsync", int'(busA.hsync), 1);
        compareField("async reset A.active", int'(busA.active), 0);
        compareField("async reset B.vsync", int'(busB.vsync), 0);
        repeat (2) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkFirstEdge("after reset");

        repeat (4) applyStimulus(1'b0, 1'b0);
        @(posedge clock);
        #4;
        compareField("scoreboard A drained", expA.size(), 0);
        compareField("scoreboard B drained", expB.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
Raster timing generator feeding the VGA pixel/colour stage, clocked by the PLL pixel clock. Produces registered hsync/vsync/active and pixel coordinates x/y so a downstream pattern or framebuffer stage can compute RGB. A programmable sync delay line keeps the sync signals aligned with the colour pipeline's latency. Default timing is 640x480@60 (25.175 MHz nominal pixel clock).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hsync (0 = active-low)
VSYNC_POL, 0, asserted level of vsync
CW, 10, width of the counters and of x/y
SYNC_DELAY, 0, extra pix_en-qualified stages on hsync/vsync/active (0..7)

Ports:
clock  input  1  pixel clock from PLL
reset  input  1  asynchronous, active-high reset
pix_en  input  1  pixel-step enable; tie high for one pixel per clock
x  output  CW  horizontal position of current output pixel
y  output  CW  vertical position of current output line
active  output  1  high inside visible area (delayed by SYNC_DELAY)
hsync  output  1  horizontal sync (delayed by SYNC_DELAY)
vsync  output  1  vertical sync (delayed by SYNC_DELAY)
line_start  output  1  single-clock pulse when x/y update to h=0
frame_start  output  1  single-clock pulse when x/y update to (0,0)

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high. Port names are clock and reset.
- Internal counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1). H_TOTAL = sum of the H_* parameters = 800. V_TOTAL = 525.
- Reset values: h=v=0, x=y=0, active=0, line_start=frame_start=0. hsync=!HSYNC_POL, vsync=!VSYNC_POL. All delay-line stages are cleared to the same inactive values.
- When pix_en=1 at a clock edge:
  - Outputs load from the current h/v: x<=h, y<=v, active_raw<=(h<H_ACTIVE && v<V_ACTIVE).
  - hsync_raw is asserted for h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] (656..751).
  - vsync_raw is asserted for v in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1] (490..491), for the whole line including h=0.
  - h then increments. At h=H_TOTAL-1, h wraps to 0 and v increments. At v=V_TOTAL-1 with h=H_TOTAL-1, both wrap to 0.
- Latency: x/y and the raw sync/active signals lag the counters by one enabled step.
- The active/hsync/vsync outputs pass through SYNC_DELAY further stages, each advancing only when pix_en=1. With SYNC_DELAY=0 the outputs equal the raw signals.
- When pix_en=0, all counters, x/y and delay stages hold their values.
- line_start <= pix_en && h==0, evaluated every clock, so the pulse is exactly one clock wide even when pix_en stays high. frame_start <= pix_en && h==0 && v==0.
- First enabled edge after reset: x=0, y=0, active=1, line_start=frame_start=1.
- Reset asserted mid-frame: all state returns to reset values immediately. After release the raster restarts at (0,0); no partial line is completed.
- Width rule: CW must hold H_TOTAL-1 and V_TOTAL-1. Violating this is a configuration error, flagged by elaboration assertion.

Decomposition:
- Package vga_pkg: the default 640x480@60 timing constants, derived H_TOTAL/V_TOTAL, and sync-polarity constants, shared with the colour/pattern stage.
- One sub-module, vga_axis_counter, instantiated twice (horizontal and vertical):
  - inputs: step enable, wrap;
  - outputs: count, terminal-count flag, in-sync-window, in-active.
- The top-level vga_timing holds the output registers and the delay line.

Test Plan:
- Reset, then pix_en=1 constant -> first edge x=0, y=0, active=1, frame_start=1 for exactly one clock; hsync=vsync=1 (inactive).
- Line timing -> hsync falling edges 800 clocks apart; hsync low for 96 clocks, starting when x=656; active high for 640 clocks per line.
- Frame timing -> vsync low for 1600 clocks (lines 490–491); vsync period 420000 clocks; 307200 active clocks and one frame_start per frame.
- pix_en toggling 1,0,1,0 -> all periods double (hsync period 1600 clocks); line_start/frame_start still one clock wide; x/y hold during pix_en=0.
- SYNC_DELAY=2 -> hsync falls 2 enabled steps after x becomes 656; active falls 2 steps after x becomes 640.
- Reset asserted at (x=300, y=200) for 3 clocks -> outputs return to reset values asynchronously; next enabled edge after release gives (0,0) with frame_start=1.
